div_seq: RTL and testbench

//  Multi-cycle sequencer for the HI/LO divide path (DIV/DIVU). It accepts operands from the EX stage,

---
 rtl/div_seq_pkg.sv | 16 +
 rtl/div_seq_step.sv | 25 ++
 rtl/div_seq.sv | 151 +++++++++++++++
 tb/tb_div_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/div_seq_pkg.sv
// Shared types for the HI/LO divide sequencer.
package div_seq_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_BUSY = 2'b01,
    DIV_DONE = 2'b10
  } div_state_e;

  function automatic logic neg_quo(input logic sa, input logic sb);
    return sa ^ sb;
  endfunction

endpackage

// File: rtl/div_seq_step.sv
// One radix-2 restoring divide step (combinational).
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] next_rem,
  output logic             q_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             unused_bits;

  assign shifted  = {rem, dvd_msb};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign q_bit    = ~trial[WIDTH+1];
  assign next_rem = q_bit ? trial[WIDTH-1:0]
                          : shifted[WIDTH-1:0];

  // Partial remainder stays below the divisor, so these never carry info.
  assign unused_bits = ^{trial[WIDTH], shifted[WIDTH]};

endmodule

// File: rtl/div_seq.sv
// DIV/DIVU sequencer: restoring divide, {rem, quo} result.
// Build option DIV_EARLY_OUT_EN skips iterations when |a| < |b|.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic               signed_div,
  input  logic [WIDTH-1:0]   opa,
  input  logic [WIDTH-1:0]   opb,
  input  logic               annul,
  input  logic               ack,
  output logic               busy,
  output logic               ready,
  output logic               div_by_zero,
  output logic [2*WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  div_state_e         state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvd_q;
  logic [WIDTH-1:0]   dvsr_q;
  logic               negq_q;
  logic               negr_q;
  logic               busy_q;
  logic               ready_q;
  logic               dbz_q;
  logic [2*WIDTH-1:0] result_q;

  logic               sa;
  logic               sb;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH-1:0]   rem_d;
  logic               qbit;
  logic [WIDTH-1:0]   quo_raw;
  logic [2*WIDTH-1:0] result_d;

  assign sa    = signed_div & opa[WIDTH-1];
  assign sb    = signed_div & opb[WIDTH-1];
  assign abs_a = sa ? (~opa + 1'b1) : opa;
  assign abs_b = sb ? (~opb + 1'b1) : opb;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .dvd_msb  (dvd_q[WIDTH-1]),
    .divisor  (dvsr_q),
    .next_rem (rem_d),
    .q_bit    (qbit)
  );

  assign quo_raw = {dvd_q[WIDTH-2:0], qbit};

  always_comb begin
    result_d = {rem_d, quo_raw};
    if (negr_q) result_d[2*WIDTH-1:WIDTH] = ~rem_d + 1'b1;
    if (negq_q) result_d[WIDTH-1:0]       = ~quo_raw + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= DIV_IDLE;
      cnt_q    <= '0;
      rem_q    <= '0;
      dvd_q    <= '0;
      dvsr_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
      dbz_q    <= 1'b0;
      result_q <= '0;
    end else if (annul) begin
      state_q <= DIV_IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      unique case (state_q)
        DIV_IDLE: begin
          if (start) begin
            negq_q <= neg_quo(sa, sb);
            negr_q <= sa;
            rem_q  <= '0;
            dvd_q  <= abs_a;
            dvsr_q <= abs_b;
            cnt_q  <= CW'(WIDTH - 1);
            unique case (1'b1)
              (opb == '0): begin
                state_q  <= DIV_DONE;
                ready_q  <= 1'b1;
                dbz_q    <= 1'b1;
                result_q <= {opa, {WIDTH{1'b1}}};
              end
`ifdef DIV_EARLY_OUT_EN
              (abs_a < abs_b): begin
                state_q  <= DIV_DONE;
                ready_q  <= 1'b1;
                dbz_q    <= 1'b0;
                result_q <= {opa, {WIDTH{1'b0}}};
              end
`endif
              default: begin
                state_q <= DIV_BUSY;
                busy_q  <= 1'b1;
              end
            endcase
          end
        end
        DIV_BUSY: begin
          rem_q <= rem_d;
          dvd_q <= quo_raw;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q  <= DIV_DONE;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
            dbz_q    <= 1'b0;
            result_q <= result_d;
          end
        end
        DIV_DONE: begin
          // start is deliberately not looked at here; it is taken next cycle.
          if (ack) begin
            state_q <= DIV_IDLE;
            ready_q <= 1'b0;
            dbz_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= DIV_IDLE;
          busy_q  <= 1'b0;
          ready_q <= 1'b0;
          dbz_q   <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign ready       = ready_q;
  assign div_by_zero = dbz_q;
  assign result      = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: latency, sign fix, zero divisor,
// annul, DONE hold, ack/restart and async reset.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        signed_div = 1'b0;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        annul = 1'b0;
  logic        ack = 1'b0;
  logic        busy;
  logic        ready;
  logic        div_by_zero;
  logic [63:0] result;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  div_seq dut (
    .clk         (clk),
    .resetn      (resetn),
    .start       (start),
    .signed_div  (signed_div),
    .opa         (opa),
    .opb         (opb),
    .annul       (annul),
    .ack         (ack),
    .busy        (busy),
    .ready       (ready),
    .div_by_zero (div_by_zero),
    .result      (result)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic sg, input logic [31:0] a,
                        input logic [31:0] b);
    signed_div = sg;
    opa = a;
    opb = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (!ready && lat < 100) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic release_done();
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
  endtask

  task automatic do_div(input string tag, input logic sg,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic exp_dbz,
                        input logic [63:0] exp_res);
    int lat;
    launch(sg, a, b);
    wait_ready(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_dbz"}, 64'(div_by_zero), 64'(exp_dbz));
    release_done();
  endtask

  initial begin
    int lat;
    logic seen;
    logic [63:0] held;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_res", result, 64'd0);
    resetn = 1'b1;
    @(posedge clk);
    #1;

    // Latency counts edges after the accepting edge: 32 full, 0 short.
    launch(1'b0, 32'd100, 32'd7);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_ready(lat);
    chk("t1_lat", 64'(lat), 64'd32);
    chk("t1_res", result, {32'd2, 32'd14});
    chk("t1_dbz", 64'(div_by_zero), 64'd0);
    release_done();
    chk("t1_rel", 64'(ready), 64'd0);

    do_div("neg7d2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32, 1'b0,
           {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("7dneg2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32, 1'b0,
           {32'h0000_0001, 32'hFFFF_FFFD});
    do_div("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, 1'b0,
           {32'h0, 32'h8000_0000});
    do_div("umax", 1'b0, 32'hFFFF_FFFF, 32'd1, 32, 1'b0,
           {32'h0, 32'hFFFF_FFFF});
    do_div("dz", 1'b1, 32'd5, 32'd0, 0, 1'b1,
           {32'd5, 32'hFFFF_FFFF});

    launch(1'b0, 32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(posedge clk);
    #1 annul = 1'b0;
    chk("ann_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1 if (ready) seen = 1'b1;
    end
    chk("ann_noready", 64'(seen), 64'd0);
    do_div("after_ann", 1'b0, 32'd9, 32'd3, 32, 1'b0,
           {32'd0, 32'd3});

    launch(1'b0, 32'd9, 32'd3);
    wait_ready(lat);
    held = result;
    chk("hold_val", held, {32'd0, 32'd3});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_rdy", 64'(ready), 64'd1);
      chk("hold_res", result, {32'd0, 32'd3});
    end
    opa = 32'd100;
    opb = 32'd7;
    signed_div = 1'b0;
    start = 1'b1;
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    chk("ack_rdy", 64'(ready), 64'd0);
    chk("ack_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    chk("restart_busy", 64'(busy), 64'd1);
    repeat (5) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_ready", 64'(ready), 64'd0);
    chk("arst_dbz", 64'(div_by_zero), 64'd0);
    chk("arst_res", result, 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk);
    #1;

`ifdef DIV_EARLY_OUT_EN
    do_div("early", 1'b0, 32'd3, 32'd10, 0, 1'b0,
           {32'd3, 32'd0});
`else
    do_div("noearly", 1'b0, 32'd3, 32'd10, 32, 1'b0,
           {32'd3, 32'd0});
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
